// File: rtl/cube_layer_scheduler.sv
// rtl/cube_layer_scheduler.sv - layer-by-layer frame sequencer for an 8x8x8 LED cube
//
// For each layer the block does four things in order:
//   1. It reads the layer's column word from the double-buffered frame memory.
//   2. It shifts the word out MSB first on sr_data/sr_clk.
//   3. It latches the column registers.
//   4. It starts the layer activator and waits for that activator's done pulse.
// A requested display-buffer swap is only applied when the last layer of a frame
// completes, so a displayed frame never mixes data from two buffers.
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   enable            level, keep scanning while high
//   swap_req          1-cycle request to toggle the display buffer
//   mem_rd_en/addr    frame memory read strobe and {buffer_sel, layer}
//   mem_rd_data       column word, valid the cycle after mem_rd_en
//   sr_data/clk/latch serial column interface to the column shift registers
//   act_start/layer   layer activator start pulse and layer index
//   act_done          layer activator done pulse
//   swap_ack          pulse when the buffer toggle takes effect
//   frame_done        pulse when the last layer of a frame completes
//   busy              high whenever not idle

module cube_layer_scheduler #(
    parameter int NUM_LAYERS = 8,
    parameter int COLS       = 64,
    parameter int SR_HALF    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          swap_req,
    output logic                          mem_rd_en,
    output logic [$clog2(NUM_LAYERS):0]   mem_rd_addr,
    input  logic [COLS-1:0]               mem_rd_data,
    output logic                          sr_data,
    output logic                          sr_clk,
    output logic                          sr_latch,
    output logic                          act_start,
    output logic [$clog2(NUM_LAYERS)-1:0] act_layer,
    input  logic                          act_done,
    output logic                          swap_ack,
    output logic                          frame_done,
    output logic                          busy
);

    localparam int LW = $clog2(NUM_LAYERS);
    localparam int BW = $clog2(COLS);
    localparam int PW = $clog2(2 * SR_HALF);

    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(COLS - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(2 * SR_HALF - 1);
    localparam logic [PW-1:0] HIGH_PHASE = PW'(SR_HALF);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPTURE, S_SHIFT, S_LATCH, S_ACTIVATE, S_WAIT_DONE, S_NEXT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [LW-1:0]    r_layer;
    logic             r_buf_sel;
    logic             r_swap_pending;
    logic [COLS-1:0]  r_shift;
    logic [BW-1:0]    r_bit;
    logic [PW-1:0]    r_phase;

    logic             w_wrap;
    logic             w_bit_end;
    logic             w_swap_now;

    assign w_wrap     = (r_state == S_NEXT) && (r_layer == LAST_LAYER);
    assign w_bit_end  = (r_phase == LAST_PHASE);
    // A request arriving on the wrap cycle itself is honoured immediately.
    assign w_swap_now = w_wrap && (r_swap_pending || swap_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_rd_en    = 1'b0;
        mem_rd_addr  = '0;
        sr_data      = 1'b0;
        sr_clk       = 1'b0;
        sr_latch     = 1'b0;
        act_start    = 1'b0;
        act_layer    = '0;
        swap_ack     = w_swap_now;
        frame_done   = w_wrap;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (enable) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_rd_en    = 1'b1;
                mem_rd_addr  = {r_buf_sel, r_layer};
                w_next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                // Bit held for the whole low+high period; clock is high in the second half.
                sr_data = r_shift[COLS-1];
                sr_clk  = (r_phase >= HIGH_PHASE);
                if (w_bit_end && (r_bit == LAST_BIT)) w_next_state = S_LATCH;
            end
            S_LATCH: begin
                sr_latch     = 1'b1;
                w_next_state = S_ACTIVATE;
            end
            S_ACTIVATE: begin
                act_start    = 1'b1;
                act_layer    = r_layer;
                w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                act_layer = r_layer;
                if (act_done) w_next_state = S_NEXT;
            end
            S_NEXT: begin
                w_next_state = enable ? S_FETCH : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_layer        <= '0;
            r_buf_sel      <= 1'b0;
            r_swap_pending <= 1'b0;
            r_shift        <= '0;
            r_bit          <= '0;
            r_phase        <= '0;
        end else begin
            if (swap_req && !w_wrap) r_swap_pending <= 1'b1;
            case (r_state)
                S_CAPTURE: begin
                    r_shift <= mem_rd_data;
                    r_bit   <= '0;
                    r_phase <= '0;
                end
                S_SHIFT: begin
                    if (w_bit_end) begin
                        r_phase <= '0;
                        r_bit   <= r_bit + BW'(1);
                        r_shift <= {r_shift[COLS-2:0], 1'b0};
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                S_NEXT: begin
                    if (r_layer == LAST_LAYER) begin
                        r_layer <= '0;
                        if (w_swap_now) begin
                            r_buf_sel      <= ~r_buf_sel;
                            r_swap_pending <= 1'b0;
                        end
                    end else begin
                        r_layer <= r_layer + LW'(1);
                    end
                    // Re-enabling always restarts the frame from layer 0.
                    if (!enable) r_layer <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
